// File: rtl/fetch_unit.sv
// Instruction fetch front end: next-PC register, in-order imem request/response
// handling with stale-response dropping, and a small {pc, instr} FIFO feeding IF/ID.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Stall,
  input  logic        flush,
  input  logic [31:0] Branch_Target,
  input  logic        csr_flush,
  input  logic [31:0] csr_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Instruction,
  output logic [31:0] PC
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned PW   = $clog2(DEPTH);
  localparam int unsigned CW   = PW + 1;
  localparam logic [XLEN-1:0] ALIGN_MASK = 32'hFFFF_FFFC;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  fetch_entry_t    fifo_q [DEPTH];
  fetch_entry_t    head_c;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] resp_pc_q, resp_pc_d;
  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   drop_q, drop_d;

  logic            redirect_c;
  logic [XLEN-1:0] target_c;
  logic [CW:0]     occupancy_c;
  logic            issue_c;
  logic            push_c;
  logic            pop_c;

  // resp_pc tracks the pc of the next non-dropped response: requests are
  // sequential between redirects and responses return in order.
  always_comb begin
    redirect_c    = csr_flush | flush;
    target_c      = csr_flush ? csr_pc : Branch_Target;
    occupancy_c   = {1'b0, outstanding_q} + {1'b0, count_q};
    imem_req      = rst & ~redirect_c & (occupancy_c < (CW+1)'(DEPTH));
    imem_addr     = fetch_pc_q;
    issue_c       = imem_req & imem_gnt;
    push_c        = rst & imem_rvalid & ~redirect_c & (drop_q == '0);
    pop_c         = rst & ~Stall & ~redirect_c & (count_q != '0);

    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;
    outstanding_d = outstanding_q;
    drop_d        = drop_q;

    if (redirect_c) begin
      fetch_pc_d    = target_c & ALIGN_MASK;
      resp_pc_d     = target_c & ALIGN_MASK;
      head_d        = '0;
      tail_d        = '0;
      count_d       = '0;
      outstanding_d = outstanding_q - CW'(imem_rvalid);
      drop_d        = outstanding_q - CW'(imem_rvalid);
    end else begin
      if (issue_c) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      outstanding_d = outstanding_q + CW'(issue_c) - CW'(imem_rvalid);
      if (imem_rvalid && (drop_q != '0)) begin
        drop_d = drop_q - CW'(1);
      end
      if (push_c) begin
        tail_d    = tail_q + PW'(1);
        resp_pc_d = resp_pc_q + 32'd4;
      end
      if (pop_c) begin
        head_d = head_q + PW'(1);
      end
      count_d = count_q + CW'(push_c) - CW'(pop_c);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc_q    <= RESET_PC & ALIGN_MASK;
      resp_pc_q     <= RESET_PC & ALIGN_MASK;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      outstanding_q <= '0;
      drop_q        <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
    end
  end

  // FIFO storage needs no reset; occupancy is governed by count_q.
  always_ff @(posedge clk) begin
    if (push_c) begin
      fifo_q[tail_q] <= '{pc: resp_pc_q, instr: imem_rdata};
    end
  end

  always_comb begin
    head_c = fifo_q[head_q];
    if (rst && (count_q != '0)) begin
      Instruction = head_c.instr;
      PC          = head_c.pc;
    end else begin
      Instruction = NOP;
      PC          = '0;
    end
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch front end that produces the `PC` and `Instruction` pair consumed by the IF/ID pipeline register. It runs a next-PC register and issues in-order requests to instruction memory over a request/grant, response-valid handshake. It buffers returned words in a small FIFO and presents them one per cycle, or a NOP bubble when nothing is ready. It honours the same `Stall`, `flush` (branch redirect) and `csr_flush` (trap/return redirect) controls as the pipeline register, and discards responses made stale by a redirect.

## Interface
- `RESET_PC`, default `32'h0000_0000`: first fetch address after reset.
- `DEPTH`, default 4: FIFO entries, and also the maximum of (outstanding requests + buffered entries). Power of two, ≥2.
- `NOP`, default `32'h0000_0013`: bubble instruction (`addi x0,x0,0`).

- `clk`, in, 1: clock. All logic is on the rising edge.
- `rst`, in, 1: reset. Synchronous, active-low (`rst==0` resets).
- `Stall`, in, 1: hold the current output; do not pop the FIFO.
- `flush`, in, 1: branch/jump redirect to `Branch_Target`.
- `Branch_Target`, in, 32: redirect address for `flush`.
- `csr_flush`, in, 1: trap/mret redirect to `csr_pc`. Takes priority over `flush`.
- `csr_pc`, in, 32: redirect address for `csr_flush`.
- `imem_req`, out, 1: request valid.
- `imem_addr`, out, 32: word-aligned request address (bits [1:0] = 0).
- `imem_gnt`, in, 1: request accepted this cycle.
- `imem_rvalid`, in, 1: response valid. Responses arrive in request order, at least 1 cycle after grant.
- `imem_rdata`, in, 32: response word.
- `Instruction`, out, 32: to the IF/ID register.
- `PC`, out, 32: address of `Instruction`.

## Operation
- **Registers:**
  - `fetch_pc`: address of the next request.
  - FIFO of {pc, instr}, `DEPTH` entries, with `count`.
  - `outstanding` counter for granted requests not yet answered.
  - `drop` counter for responses to discard.
- **Issue:**
  - `imem_req = rst & ~redirect & (outstanding + count < DEPTH)`.
  - `imem_addr = fetch_pc`.
  - On `imem_req & imem_gnt`: `fetch_pc += 4` and `outstanding++`. `imem_addr` stays stable while `req & ~gnt`.
- **Response:**
  - On `imem_rvalid`: `outstanding--`.
  - If `drop > 0`: `drop--` and the word is discarded.
  - Otherwise push {pc of that request, `imem_rdata`}. Pc values are tracked in a parallel in-flight queue, or computed from the FIFO tail pc + 4.
- **Output:**
  - FIFO non-empty: `Instruction` and `PC` come from the head.
  - FIFO empty: `Instruction = NOP`, `PC = 32'h0`.
  - Pop when `~Stall & count>0 & ~redirect`.
- **Redirect:** `redirect = csr_flush | flush`; target is `csr_flush ? csr_pc : Branch_Target`. In the redirect cycle:
  - FIFO is cleared (count=0).
  - `fetch_pc = {target[31:2], 2'b00}`.
  - `drop` = `outstanding` after this cycle's increments and decrements, excluding any response arriving this cycle.
  - No request is issued.
  - A redirect with `Stall=1` still redirects. The downstream register inserts its own NOP.
- **Simultaneous events:**
  - Push and pop in the same cycle leaves count unchanged.
  - A response arriving in the redirect cycle is discarded.
  - Grant and rvalid in the same cycle leave `outstanding` unchanged.
- **Reset:**
  - `fetch_pc = RESET_PC`; count, outstanding and drop are cleared.
  - `imem_req = 0`; outputs are NOP / 0.
  - Reset mid-transaction abandons in-flight responses. Memory is reset on the same `rst`, so stale `rvalid` does not occur.

## Timing
- `imem_req` asserts in the first cycle with `rst==1`, with `imem_addr = RESET_PC`.
- Latency: a grant in cycle t with response in cycle t+L gives the word on `Instruction` in cycle t+L+1. Registered FIFO, no bypass.
- With `L=1`, `gnt` always high, `DEPTH=4` and no stall: one instruction per cycle, steady state.
- Redirect in cycle r:
  - Earliest new request in cycle r+1 at the target.
  - With `L=1`, the first target instruction appears in cycle r+3. Cycles r+1 and r+2 output NOP.
- `Stall` holds `Instruction`/`PC` unchanged while count>0. Requests continue until `outstanding + count == DEPTH`.

## Test plan
- **Reset/stream:** `rst` low 3 cycles then high; `gnt=1`, L=1, mem[i]=i → requests 0x0, 0x4, 0x8…; `Instruction` shows NOP for 2 cycles, then 0, 1, 2… with PC 0x0, 0x4, 0x8 each cycle.
- **Stall/backpressure:** `Stall=1` for 6 cycles mid-stream → outputs frozen; `imem_req` drops once outstanding + count = 4; stream resumes without loss or duplication after release.
- **Branch flush with stale data:** L=3, flush with `Branch_Target=0x100` while 3 requests are in flight → those 3 responses are discarded; the next non-NOP output is PC=0x100.
- **Priority:** `csr_flush` (`csr_pc=0x200`) and `flush` (`Branch_Target=0x100`) in the same cycle → next request and next instruction at 0x200.
- **Grant stall:** `gnt=0` for 4 cycles → `imem_addr` stays stable at the pending address and the PC sequence is unbroken; `Branch_Target=0x103` is fetched as 0x100.
- **Mid-flight reset:** reset with 2 requests outstanding → all counters are cleared, and fetch restarts at `RESET_PC` with no stale pushes.
